// File: rtl/qbert_map_pkg.sv
// ============================================================================
//  Module      : qbert_map_pkg
//  Description : Shared types and helpers for the Qbert pyramid map.
//                It holds the tile colouring modes, the RGB face colours,
//                the cube count and cube index functions, and the pause-tint
//                saturating add.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package qbert_map_pkg;

   // Colouring rule applied to a tile when Qbert lands on it
   typedef enum logic [1:0] {
      MODE_DIRECT     = 2'd0,
      MODE_STEP       = 2'd1,
      MODE_TOGGLE     = 2'd2,
      MODE_DIRECT_ALT = 2'd3
   } mode_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t c_rgb_bg     = '{r: 8'd0,   g: 8'd0,   b: 8'd0};
   localparam rgb_t c_rgb_left   = '{r: 8'd86,  g: 8'd169, b: 8'd152};
   localparam rgb_t c_rgb_right  = '{r: 8'd49,  g: 8'd70,  b: 8'd70};
   localparam rgb_t c_rgb_top0   = '{r: 8'd222, g: 8'd222, b: 8'd0};
   localparam rgb_t c_rgb_topmid = '{r: 8'd255, g: 8'd255, b: 8'd255};
   localparam rgb_t c_rgb_topt   = '{r: 8'd86,  g: 8'd70,  b: 8'd239};

   localparam logic [8:0] c_tint_add = 9'd50;

   function automatic int n_cube(input int n_rank);
      return n_rank * (n_rank + 1) / 2;
   endfunction

   function automatic int cube_idx(input int r, input int k);
      return r * (r + 1) / 2 + k;
   endfunction

   function automatic logic [7:0] tint_sat(input logic [7:0] v);
      logic [8:0] s;
      s = {1'b0, v} + c_tint_add;
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/qbert_pyramid_map_if.sv
// ============================================================================
//  Module      : qbert_pyramid_map_if
//  Description : Game-control bus of the pyramid map: Qbert position,
//                landing/clear/mode controls and the map status outputs.
//                master = game logic, slave = pyramid map.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface qbert_pyramid_map_if
   import qbert_map_pkg::*;
#(
   parameter int N_CUBE = 28,
   parameter int CW     = 2
);
   logic [20:0]          qbert_xy;    // {x[10:0], y[9:0]} Qbert centre
   logic                 land;        // one-cycle landing pulse
   logic                 clear;       // level restart
   mode_e                mode;        // colouring rule, used with land
   logic [N_CUBE-1:0]    position_qb; // one-hot occupied cube
   logic [N_CUBE*CW-1:0] tile_state;  // cube i at [i*CW +: CW]
   logic                 off_map;     // land outside every cube
   logic                 level_done;  // all tiles at target

   modport master (
      output qbert_xy, land, clear, mode,
      input  position_qb, tile_state, off_map, level_done
   );

   modport slave (
      input  qbert_xy, land, clear, mode,
      output position_qb, tile_state, off_map, level_done
   );
endinterface

`default_nettype wire

// File: rtl/qbert_cube_tile.sv
// ============================================================================
//  Module      : qbert_cube_tile
//  Description : One pyramid cube: tile state register, Qbert landing box
//                and stage-1 top/left/right face flags for the pixel path.
//  Ports       : clk/rst, geometry (i_x1,i_y1,i_xd,i_yd,i_xlength), Qbert
//                centre (i_qx,i_qy), pixel (i_x,i_y), i_land (update this
//                tile), i_clear, i_mode; o_in_box, o_state, o_top/left/right.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module qbert_cube_tile
   import qbert_map_pkg::*;
#(
   parameter int RANK = 0,
   parameter int POS  = 0,
   parameter int T    = 2,
   parameter int CW   = 2
)(
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic [10:0]   i_x1,
   input  wire logic [9:0]    i_y1,
   input  wire logic [10:0]   i_xd,
   input  wire logic [9:0]    i_yd,
   input  wire logic [10:0]   i_xlength,
   input  wire logic [10:0]   i_qx,
   input  wire logic [9:0]    i_qy,
   input  wire logic [10:0]   i_x,
   input  wire logic [9:0]    i_y,
   input  wire logic          i_land,
   input  wire logic          i_clear,
   input  wire logic [1:0]    i_mode,
   output logic               o_in_box,
   output logic [CW-1:0]      o_state,
   output logic               o_top,
   output logic               o_left,
   output logic               o_right
);
   localparam logic [CW-1:0] c_T = CW'(T);

   logic [10:0]   w_x0;
   logic [9:0]    w_y0;
   logic [12:0]   w_ex0, w_ey0, w_exd, w_eyd, w_exl, w_xd4, w_yd4;
   logic [12:0]   w_qx, w_qy, w_px, w_py;
   logic          w_box, w_top, w_dx_side, w_left, w_right;
   logic [CW-1:0] w_next;
   logic [CW-1:0] r_state;
   logic          r_in_box, r_top, r_left, r_right;

   // Top point of the cube, wrapping at the pixel counter widths
   assign w_x0 = i_x1 + 11'(RANK) * (i_xd + i_xlength + 11'd1);
   assign w_y0 = i_y1 - 10'(RANK) * (i_yd + 10'd1) + 10'(POS) * (i_yd + i_yd + 10'd1);

   // Compare in 13 bits so no sum can wrap; subtractions are moved across
   assign w_ex0 = 13'(w_x0);
   assign w_ey0 = 13'(w_y0);
   assign w_exd = 13'(i_xd);
   assign w_eyd = 13'(i_yd);
   assign w_exl = 13'(i_xlength);
   assign w_xd4 = 13'(i_xd >> 2);
   assign w_yd4 = 13'(i_yd >> 2);
   assign w_qx  = 13'(i_qx);
   assign w_qy  = 13'(i_qy);
   assign w_px  = 13'(i_x);
   assign w_py  = 13'(i_y);

   assign w_box = (w_qx + w_xd4 >= w_ex0) && (w_qx <= w_ex0 + w_xd4) &&
                  (w_qy + w_yd4 >= w_ey0 + w_eyd) && (w_qy <= w_ey0 + w_eyd + w_yd4);

   assign w_top = (w_px + w_exd >= w_ex0) && (w_px <= w_ex0 + w_exd) &&
                  (w_py >= w_ey0) && (w_py <= w_ey0 + w_eyd + w_eyd);

   assign w_dx_side = (w_px >= w_ex0 + w_exd + 13'd1) && (w_px <= w_ex0 + w_exd + w_exl);
   assign w_left    = w_dx_side && (w_py >= w_ey0) && (w_py <= w_ey0 + w_eyd);
   assign w_right   = w_dx_side && (w_py >= w_ey0 + w_eyd + 13'd1) &&
                      (w_py <= w_ey0 + w_eyd + w_eyd);

   always_comb begin
      w_next = c_T;
      case (mode_e'(i_mode))
         MODE_STEP:   w_next = (r_state >= c_T) ? c_T : r_state + CW'(1);
         MODE_TOGGLE: w_next = (r_state < c_T) ? r_state + CW'(1) : c_T - CW'(1);
         default:     w_next = c_T;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= '0;
         r_in_box <= 1'b0;
         r_top    <= 1'b0;
         r_left   <= 1'b0;
         r_right  <= 1'b0;
      end else begin
         r_in_box <= w_box;
         r_top    <= w_top;
         r_left   <= w_left;
         r_right  <= w_right;
         if (i_clear)
            r_state <= '0;
         else if (i_land)
            r_state <= w_next;
      end
   end

   assign o_in_box = r_in_box;
   assign o_state  = r_state;
   assign o_top    = r_top;
   assign o_left   = r_left;
   assign o_right  = r_right;

endmodule

`default_nettype wire

// File: rtl/qbert_pyramid_map.sv
// ============================================================================
//  Module      : qbert_pyramid_map
//  Description : Qbert pyramid map. Tracks which cube Qbert stands on,
//                colours tiles on landing, detects level completion and
//                renders the pyramid faces through a 2-stage pixel pipeline.
//  Ports       : CLK_33, reset, x_cnt/y_cnt pixel position, XLENGTH,
//                XYDIAG_DEMI, RANK1_XY_OFFSET geometry, bus (game-control
//                slave modport), red/green/blue; pause when
//                PYRAMID_PAUSE_TINT_EN is defined (brightens the picture).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module qbert_pyramid_map
   import qbert_map_pkg::*;
#(
   parameter int N_RANK      = 7,
   parameter int COLOR_STEPS = 2
)(
   input  wire logic          CLK_33,
   input  wire logic          reset,
   input  wire logic [10:0]   x_cnt,
   input  wire logic [9:0]    y_cnt,
   input  wire logic [10:0]   XLENGTH,
   input  wire logic [20:0]   XYDIAG_DEMI,
   input  wire logic [20:0]   RANK1_XY_OFFSET,
`ifdef PYRAMID_PAUSE_TINT_EN
   input  wire logic          pause,
`endif
   qbert_pyramid_map_if.slave bus,
   output logic [7:0]         red,
   output logic [7:0]         green,
   output logic [7:0]         blue
);
   localparam int N_CUBE = n_cube(N_RANK);
   localparam int CW     = $clog2(COLOR_STEPS + 1);

   logic [N_CUBE-1:0] w_pos, w_top, w_left, w_right;
   logic [CW-1:0]     w_state [N_CUBE];
   logic              w_onehot, w_land_ok, w_all_t, w_top_hit;
   logic [CW-1:0]     w_top_state;
   rgb_t              w_rgb;
   rgb_t              r_rgb;
   logic              r_off_map, r_level_done;

   assign w_onehot  = (w_pos != '0) && ((w_pos & (w_pos - N_CUBE'(1))) == '0);
   // A finished level freezes every tile; clear priority is inside the tile
   assign w_land_ok = bus.land && w_onehot && !r_level_done;

   for (genvar r = 0; r < N_RANK; r++) begin : g_rank
      for (genvar k = 0; k <= r; k++) begin : g_cube
         localparam int IDX = cube_idx(r, k);
         qbert_cube_tile #(
            .RANK (r),
            .POS  (k),
            .T    (COLOR_STEPS),
            .CW   (CW)
         ) u_tile (
            .clk       (CLK_33),
            .rst       (reset),
            .i_x1      (RANK1_XY_OFFSET[20:10]),
            .i_y1      (RANK1_XY_OFFSET[9:0]),
            .i_xd      (XYDIAG_DEMI[20:10]),
            .i_yd      (XYDIAG_DEMI[9:0]),
            .i_xlength (XLENGTH),
            .i_qx      (bus.qbert_xy[20:10]),
            .i_qy      (bus.qbert_xy[9:0]),
            .i_x       (x_cnt),
            .i_y       (y_cnt),
            .i_land    (w_land_ok && w_pos[IDX]),
            .i_clear   (bus.clear),
            .i_mode    (bus.mode),
            .o_in_box  (w_pos[IDX]),
            .o_state   (w_state[IDX]),
            .o_top     (w_top[IDX]),
            .o_left    (w_left[IDX]),
            .o_right   (w_right[IDX])
         );
      end
   end

   // Pack states, detect completion and pick the lowest-index top face
   always_comb begin
      bus.tile_state = '0;
      w_all_t        = 1'b1;
      w_top_hit      = 1'b0;
      w_top_state    = '0;
      for (int i = N_CUBE - 1; i >= 0; i--) begin
         bus.tile_state[i*CW +: CW] = w_state[i];
         if (w_state[i] != CW'(COLOR_STEPS))
            w_all_t = 1'b0;
         if (w_top[i]) begin
            w_top_hit   = 1'b1;
            w_top_state = w_state[i];
         end
      end
      w_rgb = c_rgb_bg;
      if (|w_left)
         w_rgb = c_rgb_left;
      else if (|w_right)
         w_rgb = c_rgb_right;
      else if (w_top_hit) begin
         if (w_top_state == '0)
            w_rgb = c_rgb_top0;
         else if (w_top_state == CW'(COLOR_STEPS))
            w_rgb = c_rgb_topt;
         else
            w_rgb = c_rgb_topmid;
      end
`ifdef PYRAMID_PAUSE_TINT_EN
      if (pause)
         w_rgb = '{r: tint_sat(w_rgb.r), g: tint_sat(w_rgb.g), b: tint_sat(w_rgb.b)};
`endif
   end

   always_ff @(posedge CLK_33) begin
      if (reset) begin
         r_off_map    <= 1'b0;
         r_level_done <= 1'b0;
         r_rgb        <= c_rgb_bg;
      end else begin
         r_off_map <= bus.land && !w_onehot;
         if (bus.clear)
            r_level_done <= 1'b0;
         else if (w_all_t)
            r_level_done <= 1'b1;
         r_rgb <= w_rgb;
      end
   end

   assign bus.position_qb = w_pos;
   assign bus.off_map     = r_off_map;
   assign bus.level_done  = r_level_done;
   assign red             = r_rgb.r;
   assign green           = r_rgb.g;
   assign blue            = r_rgb.b;

endmodule

`default_nettype wire

// File: tb/tb_qbert_pyramid_map.sv
// ============================================================================
//  Module      : tb_qbert_pyramid_map
//  Description : Self-checking bench for qbert_pyramid_map (N_RANK=7, T=2).
//                A cycle-level reference model built from the pyramid rules
//                runs beside the DUT; directed steps plus randomized landings
//                and pixels.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qbert_pyramid_map;
   import qbert_map_pkg::*;

   localparam int NR = 7;
   localparam int NC = 28;
   localparam int T  = 2;
   localparam int XD = 16;
   localparam int YD = 10;
   localparam int XL = 12;
   localparam int X1 = 300;
   localparam int Y1 = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] x_cnt;
   logic [9:0]  y_cnt;
   logic [7:0]  red, green, blue;
`ifdef PYRAMID_PAUSE_TINT_EN
   logic        pause = 1'b0;
`endif

   qbert_pyramid_map_if #(.N_CUBE(NC), .CW(2)) bus ();

   qbert_pyramid_map #(.N_RANK(NR), .COLOR_STEPS(T)) dut (
      .CLK_33          (clk),
      .reset           (reset),
      .x_cnt           (x_cnt),
      .y_cnt           (y_cnt),
      .XLENGTH         (11'(XL)),
      .XYDIAG_DEMI     ({11'(XD), 10'(YD)}),
      .RANK1_XY_OFFSET ({11'(X1), 10'(Y1)}),
`ifdef PYRAMID_PAUSE_TINT_EN
      .pause           (pause),
`endif
      .bus             (bus),
      .red             (red),
      .green           (green),
      .blue            (blue)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cr [NC];
   int          ck [NC];
   int          st [NC];
   logic [27:0] m_pos;
   bit          m_off, m_ld;
   logic [23:0] m_rgb;
   bit          s1_v;
   int          s1x, s1y;
   bit          hold_pix = 1'b0;

   function automatic int fx0(int r);
      return (X1 + r * (XD + XL + 1)) % 2048;
   endfunction

   function automatic int fy0(int r, int k);
      int v;
      v = Y1 - r * (YD + 1) + k * (2 * YD + 1);
      return ((v % 1024) + 1024) % 1024;
   endfunction

   function automatic bit inbox(int i, int qx, int qy);
      int x0, y0;
      x0 = fx0(cr[i]);
      y0 = fy0(cr[i], ck[i]);
      return qx >= x0 - XD / 4 && qx <= x0 + XD / 4 &&
             qy >= y0 + YD - YD / 4 && qy <= y0 + YD + YD / 4;
   endfunction

   function automatic logic [23:0] colour(int x, int y);
      bit l, rt, t;
      int ts, dx, dy;
      l = 0; rt = 0; t = 0; ts = 0;
      for (int i = 0; i < NC; i++) begin
         dx = x - fx0(cr[i]);
         dy = y - fy0(cr[i], ck[i]);
         if (dx >= XD + 1 && dx <= XD + XL && dy >= 0 && dy <= YD) l = 1;
         if (dx >= XD + 1 && dx <= XD + XL && dy >= YD + 1 && dy <= 2 * YD) rt = 1;
         if (!t && dx >= -XD && dx <= XD && dy >= 0 && dy <= 2 * YD) begin
            t = 1;
            ts = st[i];
         end
      end
      if (l)       return 24'h56A998;
      if (rt)      return 24'h314646;
      if (!t)      return 24'h000000;
      if (ts == 0) return 24'hDEDE00;
      if (ts == T) return 24'h5646EF;
      return 24'hFFFFFF;
   endfunction

   function automatic int apply_mode(int s, int m);
      if (m == 1) return (s >= T) ? T : s + 1;
      if (m == 2) return (s < T) ? s + 1 : T - 1;
      return T;
   endfunction

   function automatic logic [55:0] pack_states();
      logic [55:0] v;
      for (int i = 0; i < NC; i++) v[i*2 +: 2] = 2'(st[i]);
      return v;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("position_qb", 64'(bus.position_qb), 64'(m_pos));
      chk("tile_state", 64'(bus.tile_state), 64'(pack_states()));
      chk("off_map", 64'(bus.off_map), 64'(m_off));
      chk("level_done", 64'(bus.level_done), 64'(m_ld));
      chk("rgb", 64'({red, green, blue}), 64'(m_rgb));
   endtask

   // One clock: model next state from the inputs present before the edge
   task automatic tick();
      logic [27:0] npos;
      logic [23:0] nrgb;
      int cnt, idx, qx, qy;
      bit all_t, i_rst, i_land, i_clr;
      int i_mode;
      if (!hold_pix) begin
         x_cnt = 11'($urandom_range(260, 520));
         y_cnt = 10'($urandom_range(120, 300));
      end
      qx = int'(bus.qbert_xy[20:10]);
      qy = int'(bus.qbert_xy[9:0]);
      i_rst = reset; i_land = bus.land; i_clr = bus.clear; i_mode = int'(bus.mode);
      cnt = 0; idx = 0; all_t = 1;
      for (int i = 0; i < NC; i++) begin
         npos[i] = inbox(i, qx, qy);
         if (m_pos[i]) begin cnt++; idx = i; end
         if (st[i] != T) all_t = 0;
      end
      nrgb = s1_v ? colour(s1x, s1y) : 24'h0;
      s1x = int'(x_cnt);
      s1y = int'(y_cnt);
      @(posedge clk);
      if (i_rst) begin
         for (int i = 0; i < NC; i++) st[i] = 0;
         m_pos = '0; m_off = 0; m_ld = 0; m_rgb = '0; s1_v = 0;
      end else begin
         m_off = i_land && cnt != 1;
         if (i_clr) begin
            for (int i = 0; i < NC; i++) st[i] = 0;
            m_ld = 0;
         end else begin
            if (i_land && cnt == 1 && !m_ld) st[idx] = apply_mode(st[idx], i_mode);
            if (all_t) m_ld = 1;
         end
         m_pos = npos; m_rgb = nrgb; s1_v = 1;
      end
      #1;
      check_all();
   endtask

   function automatic logic [20:0] xy_of(int i, int jx, int jy);
      return {11'(fx0(cr[i]) + jx), 10'(fy0(cr[i], ck[i]) + YD + jy)};
   endfunction

   task automatic do_land_xy(logic [20:0] xy, int m);
      bus.qbert_xy = xy;
      tick();
      bus.land = 1'b1;
      bus.mode = mode_e'(2'(m));
      tick();
      bus.land = 1'b0;
   endtask

   initial begin
      logic [55:0] saved;
      int idx, rnd;
      for (int r = 0; r < NR; r++)
         for (int k = 0; k <= r; k++) begin
            cr[r * (r + 1) / 2 + k] = r;
            ck[r * (r + 1) / 2 + k] = k;
         end
      for (int i = 0; i < NC; i++) st[i] = 0;
      m_pos = '0; m_off = 0; m_ld = 0; m_rgb = '0; s1_v = 0;
      reset = 1'b1; bus.land = 1'b0; bus.clear = 1'b0; bus.mode = MODE_DIRECT;
      bus.qbert_xy = '0; x_cnt = '0; y_cnt = '0;
      tick();
      tick();
      chk("reset_tile_state", 64'(bus.tile_state), 64'd0);
      chk("reset_rgb", 64'({red, green, blue}), 64'd0);
      reset = 1'b0;

      // Step mode on cube 0: 1, 2, saturate at 2
      do_land_xy(xy_of(0, 0, 0), 1);
      chk("step_first", 64'(bus.tile_state[1:0]), 64'd1);
      do_land_xy(xy_of(0, 0, 0), 1);
      chk("step_second", 64'(bus.tile_state[1:0]), 64'd2);
      do_land_xy(xy_of(0, 0, 0), 1);
      chk("step_saturate", 64'(bus.tile_state[1:0]), 64'd2);

      // Toggle mode on cube 4: 1, 2, 1, 2
      for (int n = 0; n < 4; n++) begin
         do_land_xy(xy_of(4, 0, 0), 2);
         chk("toggle_seq", 64'(bus.tile_state[9:8]), (n % 2 == 0) ? 64'd1 : 64'd2);
         chk("toggle_no_done", 64'(bus.level_done), 64'd0);
      end

      // Landing outside every box
      saved = bus.tile_state;
      do_land_xy({11'd5, 10'd5}, 0);
      chk("offmap_pulse", 64'(bus.off_map), 64'd1);
      tick();
      chk("offmap_one_cycle", 64'(bus.off_map), 64'd0);
      chk("offmap_tiles_kept", 64'(bus.tile_state), 64'(saved));

      // Landing box edges: inclusive at +XD/4,+YD/4; one past is off map
      do_land_xy(xy_of(5, XD / 4, YD / 4), 0);
      chk("box_edge_in", 64'(bus.tile_state[11:10]), 64'd2);
      do_land_xy(xy_of(5, XD / 4 + 1, 0), 0);
      chk("box_edge_out", 64'(bus.off_map), 64'd1);

      // Pixel pipeline on cube 0 (state 2)
      hold_pix = 1'b1;
      x_cnt = 11'(X1 - 1); y_cnt = 10'(Y1 + YD);
      tick(); tick();
      chk("pix_top_done", 64'({red, green, blue}), 64'h5646EF);
      x_cnt = 11'(X1 + XD + 1); y_cnt = 10'(Y1);
      tick(); tick();
      chk("pix_left", 64'({red, green, blue}), 64'h56A998);
      hold_pix = 1'b0;

      // Fill every cube, then freeze, then clear beats land
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("clear_tiles", 64'(bus.tile_state), 64'd0);
      for (int i = 0; i < NC; i++) do_land_xy(xy_of(i, 0, 0), 0);
      chk("done_not_yet", 64'(bus.level_done), 64'd0);
      tick();
      chk("done_asserted", 64'(bus.level_done), 64'd1);
      do_land_xy(xy_of(3, 0, 0), 2);
      chk("frozen_tile", 64'(bus.tile_state[7:6]), 64'd2);
      chk("done_held", 64'(bus.level_done), 64'd1);
      bus.clear = 1'b1; bus.land = 1'b1; bus.mode = MODE_DIRECT;
      tick();
      bus.clear = 1'b0; bus.land = 1'b0;
      chk("clear_beats_land", 64'(bus.tile_state), 64'd0);
      chk("clear_done", 64'(bus.level_done), 64'd0);

      // Reset the cycle after a landing
      do_land_xy(xy_of(6, 0, 0), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_after_land_tiles", 64'(bus.tile_state), 64'd0);
      chk("reset_after_land_pos", 64'(bus.position_qb), 64'd0);
      chk("reset_after_land_rgb", 64'({red, green, blue}), 64'd0);

      // Randomized landings, clears and pixels against the model
      for (int n = 0; n < 80; n++) begin
         rnd = int'($urandom_range(0, 99));
         if (rnd < 5) begin
            bus.clear = 1'b1;
            tick();
            bus.clear = 1'b0;
         end else if (rnd < 15) begin
            do_land_xy({11'($urandom_range(0, 99)), 10'($urandom_range(0, 99))},
                       int'($urandom_range(0, 3)));
         end else begin
            idx = int'($urandom_range(0, NC - 1));
            do_land_xy(xy_of(idx, int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 4)) - 2),
                       int'($urandom_range(0, 3)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/qbert_pyramid_map.md
QBERT_PYRAMID_MAP -- requirements
Module: qbert_pyramid_map

Interface
REQ-001 SHALL have parameter N_RANK, default 7, meaning number of pyramid ranks (1..8); N_CUBE = N_RANK*(N_RANK+1)/2.
REQ-002 SHALL have parameter COLOR_STEPS, default 2, meaning target tile state T (1..3); CW = $clog2(T+1).
REQ-003 SHALL have ports: CLK_33  in  1  pixel clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: x_cnt  in  11  pixel x; y_cnt  in  10  pixel y.
REQ-005 SHALL have ports: XLENGTH  in  11  face depth; XYDIAG_DEMI  in  21  {XD[10:0],YD[9:0]} half-diagonals; RANK1_XY_OFFSET  in  21  {X1,Y1} top point of cube 0.
REQ-006 SHALL have ports: qbert_xy  in  21  Qbert centre {x,y}; land  in  1  one-cycle landing pulse; clear  in  1  level restart pulse; mode  in  2  colouring rule.
REQ-007 SHALL have ports: position_qb  out  N_CUBE  one-hot occupied cube; tile_state  out  N_CUBE*CW  packed states, cube i at [i*CW +: CW]; off_map  out  1  pulse; level_done  out  1  all tiles at T; red/green/blue  out  8 each.

Function
REQ-008 Cube (r,k), r in 0..N_RANK-1, k in 0..r, SHALL have index r(r+1)/2+k and top point x0=X1+r*(XD+XLENGTH+1), y0=Y1-r*(YD+1)+k*(2*YD+1), 11/10-bit unsigned wrap.
REQ-009 position_qb[i] SHALL register, one cycle after qbert_xy, x0-XD/4 <= qx <= x0+XD/4 and y0+YD-YD/4 <= qy <= y0+YD+YD/4 (integer division).
REQ-010 On land, the cycle after SHALL update the single set position_qb bit's tile; if position_qb is zero or has >1 bit set, no tile changes and off_map pulses for one cycle.
REQ-011 mode 0 (direct) SHALL set state to T; mode 1 (step) SHALL increment, saturating at T; mode 2 (toggle) SHALL increment below T and set T-1 at T; mode 3 SHALL act as mode 0; mode sampled only with land.
REQ-012 level_done SHALL assert the cycle after all N_CUBE states equal T, stay high, and freeze all tiles (land ignored, off_map still reported) until clear or reset.
REQ-013 clear SHALL zero all states and level_done next cycle; clear with land in the same cycle: clear wins.
REQ-014 Pixel path SHALL be a 2-stage pipeline: stage 1 registers per-cube top/left/right flags, stage 2 registers rgb; rgb reflects x_cnt/y_cnt from 2 cycles earlier.
REQ-015 Per cube, with dx=x-x0, dy=y-y0: top = x0-XD<=x<=x0+XD and y0<=y<=y0+2YD; left = XD+1<=dx<=XD+XLENGTH and 0<=dy<=YD; right = same dx and YD+1<=dy<=2YD; comparisons SHALL be wrap-free (add to the smaller side).
REQ-016 Stage-2 priority SHALL be left (86,169,152) > right (49,70,70) > top > background (0,0,0); top colour: state 0 (222,222,0), 0<state<T (255,255,255), state T (86,70,239).

Reset
REQ-017 reset SHALL zero position_qb, tile_state, off_map, level_done, pipeline flags and rgb next edge; reset mid-landing SHALL discard the pending update.
REQ-018 reset SHALL override clear and land.

Configuration
REQ-019 With PYRAMID_PAUSE_TINT_EN defined, input pause (1 bit) SHALL exist and, when high at stage 2, add 50 to each rgb channel saturating at 255; undefined, port and logic SHALL be absent.

Structure
REQ-020 Package qbert_map_pkg SHALL hold the mode enum, the RGB colour constants, and functions for N_CUBE and cube index.
REQ-021 Sub-module qbert_cube_tile SHALL contain one cube's state register, landing box and face flags, instantiated N_CUBE times by generate.

Verification
REQ-022 N_RANK=7, T=2, mode 1: land twice on cube 0 -> tile_state[0] 1 then 2; third land stays 2.
REQ-023 Mode 2, T=2: lands on cube 4 -> 1,2,1,2; level_done never asserts while others are 0.
REQ-024 qbert_xy outside every box, land -> off_map high exactly one cycle, tile_state unchanged.
REQ-025 Mode 0, land on all 28 cubes -> level_done high one cycle after the 28th update; further land ignored; clear+land same cycle -> all states 0.
REQ-026 Pixel at x0-1,y0+YD of cube 0 with state 2 -> rgb (86,70,239) two cycles later; at x0+XD+1,y0 -> (86,169,152).
REQ-027 Reset asserted the cycle after land -> tile unchanged, all outputs 0.
